sample_stream_ctrl: RTL and testbench

Parametrised sample sequencer for the modelling datapath. It holds a host-loaded sample memory of `DEPTH` words of `DATA_W` bits and streams a programmable number of words to the processing unit over a valid/ready interface. It captures the returned results, in order, into a result memory that the host can read back. It replaces the open-loop file-read-and-print flow with a cycle-accurate, back-pressured stream that can be reused at any width or depth.

---
 rtl/sample_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sample_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_ctrl.sv
// rtl/sample_stream_ctrl.sv - sample memory sequencer streaming words out and capturing returned results
// Optional looping streams are enabled by defining SAMPLE_LOOP_EN.

module sample_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 400,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
`ifdef SAMPLE_LOOP_EN
    input  logic              loop,
`endif
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   res_cnt
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, rd_sel;
    logic [ADDR_W:0]   len_q, len_d, res_cnt_q, res_cnt_d;
    logic              m_valid_q, m_valid_d;
    logic              loop_q, loop_d, loop_now;
    logic              rd_en, xfer, at_last, res_wr, ld_ok;
    logic [DATA_W-1:0] m_data_q, rd_data_q;

    logic [DATA_W-1:0] sample_mem [DEPTH];
    logic [DATA_W-1:0] result_mem [DEPTH];

`ifdef SAMPLE_LOOP_EN
    logic loop_in;
    assign loop_in  = loop;
    // A start while streaming only updates the loop request; it never restarts the pass.
    assign loop_now = (start && state_q == STREAM) ? loop : loop_q;
`else
    logic loop_in;
    assign loop_in  = 1'b0;
    assign loop_now = loop_q;
`endif

    assign xfer    = m_valid_q && m_ready;
    assign at_last = ({1'b0, ptr_q} == (len_q - 1'b1));
    assign res_wr  = (state_q == STREAM || state_q == DRAIN) && s_valid && (res_cnt_q < len_q);
    assign ld_ok   = ld_en && (state_q == IDLE || state_q == DONE) && ({1'b0, ld_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        res_cnt_d = res_cnt_q;
        m_valid_d = m_valid_q;
        loop_d    = loop_now;
        rd_en     = 1'b0;
        rd_sel    = ptr_q;
        if (res_wr) begin
            res_cnt_d = res_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d     = len;
                    ptr_d     = '0;
                    res_cnt_d = '0;
                    m_valid_d = 1'b0;
                    loop_d    = loop_in;
                    state_d   = (len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                // The output register is refilled from the address that will be current next cycle,
                // so a held-off word re-reads nothing and a consumed word is replaced without a bubble.
                if (!m_valid_q) begin
                    rd_en     = 1'b1;
                    rd_sel    = ptr_q;
                    m_valid_d = 1'b1;
                end else if (xfer) begin
                    if (!at_last) begin
                        ptr_d  = ptr_q + 1'b1;
                        rd_sel = ptr_q + 1'b1;
                        rd_en  = 1'b1;
                    end else if (loop_now) begin
                        ptr_d     = '0;
                        rd_sel    = '0;
                        rd_en     = 1'b1;
                        res_cnt_d = '0;
                    end else begin
                        m_valid_d = 1'b0;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (res_cnt_q == len_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            len_q     <= '0;
            res_cnt_q <= '0;
            m_valid_q <= 1'b0;
            loop_q    <= 1'b0;
            m_data_q  <= '0;
            rd_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            res_cnt_q <= res_cnt_d;
            m_valid_q <= m_valid_d;
            loop_q    <= loop_d;
            if (rd_en) begin
                m_data_q <= sample_mem[rd_sel];
            end
            rd_data_q <= ({1'b0, rd_addr} < DEPTH_L) ? result_mem[rd_addr] : '0;
        end
    end

    // Memory arrays carry no reset so their contents survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            sample_mem[ld_addr] <= ld_data;
        end
        if (res_wr) begin
            result_mem[res_cnt_q[ADDR_W-1:0]] <= s_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_valid_q && at_last;
    assign rd_data = rd_data_q;
    assign busy    = (state_q == STREAM) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// tb/tb_sample_stream_ctrl.sv - directed self-checking bench for sample_stream_ctrl

module tb_sample_stream_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          start;
    logic [AW:0]   len;
    logic          loop;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   res_cnt;

    int tests;
    int fails;

    sample_stream_ctrl #(.DATA_W(DW), .DEPTH(400)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .len     (len),
`ifdef SAMPLE_LOOP_EN
        .loop    (loop),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .s_valid (s_valid),
        .s_data  (s_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .res_cnt (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a stream of n words from addr 0 (memory holds 3*addr), echo m_data+1 one cycle
    // after each transfer, and check ordering, last flag, stall stability and done timing.
    task automatic run_stream(input int n, input logic [15:0] pat, input string tag);
        int nx, first_c, last_c, done_c, bad_d, bad_l, bad_h;
        logic          pv, hv, hl;
        logic [DW-1:0] pd, hd;
        nx = 0; first_c = -1; last_c = -1; done_c = -1;
        bad_d = 0; bad_l = 0; bad_h = 0;
        pv = 1'b0; pd = '0; hv = 1'b0; hl = 1'b0; hd = '0;
        start = 1'b1;
        len   = (AW + 1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 2000; cyc++) begin
            m_ready = pat[cyc % 16];
            s_valid = pv;
            s_data  = pd;
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, "_busy_t1"}, 32'(busy), 32'd1);
                check({tag, "_valid_t1"}, 32'(m_valid), 32'd0);
            end
            if (cyc == 2) check({tag, "_valid_t2"}, 32'(m_valid), 32'd1);
            if (hv && !(m_valid === 1'b1 && m_data === hd && m_last === hl)) bad_h++;
            hv = m_valid && !m_ready;
            hd = m_data;
            hl = m_last;
            pv = 1'b0;
            if (m_valid && m_ready) begin
                if (m_data !== 32'(nx * 3)) bad_d++;
                if (m_last !== (nx == n - 1)) bad_l++;
                if (nx == 0) first_c = cyc;
                last_c = cyc;
                nx++;
                pv = 1'b1;
                pd = m_data + 1;
            end
            if (done) begin
                done_c = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        s_valid = 1'b0;
        check({tag, "_xfers"}, 32'(nx), 32'(n));
        check({tag, "_data_errs"}, 32'(bad_d), 32'd0);
        check({tag, "_last_errs"}, 32'(bad_l), 32'd0);
        check({tag, "_stall_errs"}, 32'(bad_h), 32'd0);
        check({tag, "_done_lat"}, 32'(done_c), 32'(last_c + 3));
        check({tag, "_res_cnt"}, 32'(res_cnt), 32'(n));
        if (pat == 16'hFFFF) begin
            check({tag, "_first_xfer"}, 32'(first_c), 32'd2);
            check({tag, "_no_bubbles"}, 32'(last_c - first_c), 32'(n - 1));
        end
    endtask

    initial begin
        int nx, bad;
        tests = 0; fails = 0;
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; len = '0; loop = 1'b0; m_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res_cnt", 32'(res_cnt), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 400; k++) begin
            ld_en = 1'b1; ld_addr = AW'(k); ld_data = 32'(3 * k);
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        run_stream(400, 16'hFFFF, "full");
        bad = 0;
        for (int k = 0; k < 400; k++) begin
            rd_addr = AW'(k);
            @(posedge clk); #1;
            if (rd_data !== 32'(3 * k + 1)) bad++;
        end
        check("full_readback_errs", 32'(bad), 32'd0);
        rd_addr = AW'(5);
        @(negedge clk);
        check("rd_latency_old", rd_data, 32'd1198);
        @(posedge clk); #1;
        check("rd_latency_new", rd_data, 32'd16);

        run_stream(8, 16'hA639, "bp");

        start = 1'b1; len = 10'd16;
        @(posedge clk); #1;
        start = 1'b0;
        nx = 0;
        for (int c = 0; c < 100 && nx < 5; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) nx++;
            @(posedge clk); #1;
        end
        check("mid_xfers", 32'(nx), 32'd5);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_last", 32'(m_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res_cnt", 32'(res_cnt), 32'd0);
        rst_n = 1'b1;
        run_stream(4, 16'hFFFF, "after_rst");

        start = 1'b1; len = 10'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            s_valid = (i <= 6);
            s_data  = 32'(100 + i - 1);
            ld_en   = (i == 2);
            ld_addr = AW'(2);
            ld_data = 32'hDEAD;
            if (i == 2) check("ovf_busy_at_ld", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0; ld_en = 1'b0;
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_res_cnt", 32'(res_cnt), 32'd4);
        for (int k = 0; k < 4; k++) begin
            rd_addr = AW'(k);
            @(posedge clk); #1;
            check("ovf_result", rd_data, 32'(100 + k));
        end
        rd_addr = AW'(4);
        @(posedge clk); #1;
        check("ovf_result4_untouched", rd_data, 32'd13);
        run_stream(4, 16'hFFFF, "ld_ignored");

`ifdef SAMPLE_LOOP_EN
        start = 1'b1; len = 10'd3; loop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nx = 0; bad = 0;
        for (int c = 0; c < 100 && nx < 8; c++) begin
            @(negedge clk);
            if (done) bad++;
            if (m_valid && m_ready) begin
                if (m_data !== 32'((nx % 3) * 3)) bad++;
                nx++;
            end
            @(posedge clk); #1;
        end
        check("loop_seq_errs", 32'(bad), 32'd0);
        start = 1'b1; loop = 1'b0;
        for (int c = 0; c < 50 && m_valid; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) nx++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        start = 1'b0;
        check("loop_pass_end", 32'(nx % 3), 32'd0);
        s_valid = 1'b1; s_data = 32'h55;
        for (int c = 0; c < 10 && !done; c++) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("loop_done", 32'(done), 32'd1);
`endif

        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("zero_pre_done", 32'(done), 32'd0);
        start = 1'b1; len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_done_t1", 32'(done), 32'd1);
        check("zero_res_cnt", 32'(res_cnt), 32'd0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (busy || m_valid || !done) bad++;
            @(posedge clk); #1;
        end
        check("zero_quiet_errs", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
